// File: rtl/ro_pair_sequencer.sv
// ---------------------------------------------------------------------------
// ro_pair_sequencer
//
// Runs a measurement pass over a bank of ring-oscillator pairs. For each pair
// it enables the bank and waits for the oscillators to settle. It then counts
// rising edges of both oscillators over a fixed gate window and records one
// response bit per pair (1 when oscillator A produced more edges than B).
//
// Optional feature macro: RO_COUNT_OUT_EN
//   When defined, the final counts of the last compared pair are exported on
//   cnt_a / cnt_b, together with a one-cycle cnt_valid strobe.
//
// Ports:
//   clk          in   single clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   start        in   run request, only looked at while idle
//   ro_a, ro_b   in   raw outputs of the selected pair (asynchronous to clk)
//   enable       out  oscillator enable to the bank
//   pair_select  out  index of the pair under measurement
//   busy         out  high from start acceptance until done
//   done         out  one-cycle pulse at the end of a run
//   response     out  bit i = 1 when count A > count B for pair i
//   cnt_a, cnt_b out  (RO_COUNT_OUT_EN only) final counts of last pair
//   cnt_valid    out  (RO_COUNT_OUT_EN only) pulse while in COMPARE
// ---------------------------------------------------------------------------
module ro_pair_sequencer #(
    parameter int NUM_PAIRS     = 4,
    parameter int PSEL_W        = 2,
    parameter int CNT_W         = 16,
    parameter int SETTLE_CYCLES = 8,
    parameter int GATE_CYCLES   = 1024
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 ro_a,
    input  logic                 ro_b,
    output logic                 enable,
    output logic [PSEL_W-1:0]    pair_select,
    output logic                 busy,
    output logic                 done,
    output logic [NUM_PAIRS-1:0] response
`ifdef RO_COUNT_OUT_EN
    ,
    output logic [CNT_W-1:0]     cnt_a,
    output logic [CNT_W-1:0]     cnt_b,
    output logic                 cnt_valid
`endif
);

    // The phase timer only ever has to reach the longer of the two windows.
    localparam int TMR_MAX = (SETTLE_CYCLES > GATE_CYCLES) ? SETTLE_CYCLES : GATE_CYCLES;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_GATE,
        S_COMPARE,
        S_NEXT,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [TMR_W-1:0]       timer_q, timer_d;
    logic [PSEL_W-1:0]      psel_q, psel_d;
    logic [NUM_PAIRS-1:0]   resp_q, resp_d;
    logic [CNT_W-1:0]       gate_a_q, gate_a_d;
    logic [CNT_W-1:0]       gate_b_q, gate_b_d;
    logic                   enable_q, enable_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    // [0] and [1] form the two-flop synchronizer; [2] holds the previous
    // synchronized level for rising-edge detection.
    logic [2:0]             sync_a_q, sync_a_d;
    logic [2:0]             sync_b_q, sync_b_d;
    logic                   edge_a, edge_b;

`ifdef RO_COUNT_OUT_EN
    logic [CNT_W-1:0]       cnt_a_q, cnt_a_d;
    logic [CNT_W-1:0]       cnt_b_q, cnt_b_d;
    logic                   cnt_valid_q, cnt_valid_d;
`endif

    // Input conditioning runs continuously, independent of the FSM.
    always_comb begin
        sync_a_d = {sync_a_q[1:0], ro_a};
        sync_b_d = {sync_b_q[1:0], ro_b};
        edge_a   = sync_a_q[1] & ~sync_a_q[2];
        edge_b   = sync_b_q[1] & ~sync_b_q[2];
    end

    // Sequencer next-state logic. Registered outputs are derived from the
    // next state so that enable/busy/done come straight from flops.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        psel_d   = psel_q;
        resp_d   = resp_q;
        gate_a_d = gate_a_q;
        gate_b_d = gate_b_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SETTLE;
                    timer_d = '0;
                    psel_d  = '0;
                    resp_d  = '0;
                end
            end

            S_SETTLE: begin
                gate_a_d = '0;
                gate_b_d = '0;
                if (timer_q == TMR_W'(SETTLE_CYCLES - 1)) begin
                    state_d = S_GATE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end

            S_GATE: begin
                // Saturate instead of wrapping so an overly fast oscillator
                // still compares as "large".
                if (edge_a && (gate_a_q != '1)) begin
                    gate_a_d = gate_a_q + CNT_W'(1);
                end
                if (edge_b && (gate_b_q != '1)) begin
                    gate_b_d = gate_b_q + CNT_W'(1);
                end
                if (timer_q == TMR_W'(GATE_CYCLES - 1)) begin
                    state_d = S_COMPARE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end

            S_COMPARE: begin
                for (int i = 0; i < NUM_PAIRS; i++) begin
                    if (psel_q == PSEL_W'(i)) begin
                        resp_d[i] = (gate_a_q > gate_b_q);
                    end
                end
                state_d = S_NEXT;
            end

            S_NEXT: begin
                if (psel_q == PSEL_W'(NUM_PAIRS - 1)) begin
                    state_d = S_DONE;
                end else begin
                    psel_d  = psel_q + PSEL_W'(1);
                    timer_d = '0;
                    state_d = S_SETTLE;
                end
            end

            S_DONE: begin
                psel_d  = '0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                psel_d  = '0;
            end
        endcase

        enable_d = (state_d == S_SETTLE) || (state_d == S_GATE);
        busy_d   = (state_d == S_SETTLE) || (state_d == S_GATE) ||
                   (state_d == S_COMPARE) || (state_d == S_NEXT);
        done_d   = (state_d == S_DONE);
    end

`ifdef RO_COUNT_OUT_EN
    // Capture the final gate counts on entry to COMPARE so they are visible
    // during the COMPARE cycle itself, alongside the strobe.
    always_comb begin
        cnt_a_d     = cnt_a_q;
        cnt_b_d     = cnt_b_q;
        cnt_valid_d = 1'b0;
        if (state_d == S_COMPARE) begin
            cnt_a_d     = gate_a_d;
            cnt_b_d     = gate_b_d;
            cnt_valid_d = 1'b1;
        end
    end
`endif

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            psel_q      <= '0;
            resp_q      <= '0;
            gate_a_q    <= '0;
            gate_b_q    <= '0;
            enable_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sync_a_q    <= '0;
            sync_b_q    <= '0;
`ifdef RO_COUNT_OUT_EN
            cnt_a_q     <= '0;
            cnt_b_q     <= '0;
            cnt_valid_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            psel_q      <= psel_d;
            resp_q      <= resp_d;
            gate_a_q    <= gate_a_d;
            gate_b_q    <= gate_b_d;
            enable_q    <= enable_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            sync_a_q    <= sync_a_d;
            sync_b_q    <= sync_b_d;
`ifdef RO_COUNT_OUT_EN
            cnt_a_q     <= cnt_a_d;
            cnt_b_q     <= cnt_b_d;
            cnt_valid_q <= cnt_valid_d;
`endif
        end
    end

    assign enable      = enable_q;
    assign pair_select = psel_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign response    = resp_q;
`ifdef RO_COUNT_OUT_EN
    assign cnt_a       = cnt_a_q;
    assign cnt_b       = cnt_b_q;
    assign cnt_valid   = cnt_valid_q;
`endif

endmodule

// File: tb/tb_ro_pair_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ro_pair_sequencer
//
// Scoreboard bench for ro_pair_sequencer. Two instances share clock and
// reset: the main one (CNT_W=16) and a narrow-counter one (CNT_W=3) used to
// exercise counter saturation. Oscillators are modelled as square waves whose
// period (in clk cycles) is looked up per pair from the current pair_select.
// Each accepted start pushes the expected response and the expected done
// cycle; a monitor pops and compares whenever done pulses.
// ---------------------------------------------------------------------------
module tb_ro_pair_sequencer;

    localparam int NP   = 4;
    localparam int PW   = 2;
    localparam int S    = 4;
    localparam int G    = 64;
    localparam int PAIR = S + G + 2;
    localparam int RUN  = NP * PAIR;

    typedef struct {
        logic [NP-1:0] resp;
        int            done_cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start = 1'b0;
    logic          start_s = 1'b0;

    logic          ro_a, ro_b, enable, busy, done;
    logic [PW-1:0] pair_select;
    logic [NP-1:0] response;

    logic          ro_a_s, ro_b_s, enable_s, busy_s, done_s;
    logic [PW-1:0] pair_select_s;
    logic [NP-1:0] response_s;

`ifdef RO_COUNT_OUT_EN
    logic [15:0]   cnt_a, cnt_b;
    logic          cnt_valid;
    logic [2:0]    cnt_a_s, cnt_b_s;
    logic          cnt_valid_s;
    bit            cnt_chk = 1'b0;
    int            cnt_pulses = 0;
`endif

    int   cyc = 0;
    int   tick = 0;
    int   checks = 0;
    int   fails = 0;
    exp_t sb_q[$];
    exp_t sb_s[$];

    int per_a[NP]   = '{4, 4, 4, 4};
    int per_b[NP]   = '{8, 8, 8, 8};
    int per_a_s[NP] = '{4, 6, 4, 8};
    int per_b_s[NP] = '{4, 12, 8, 4};

    always #5 clk = ~clk;

    // Edge counter: at a negedge, cyc equals the number of posedges so far.
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) tick <= tick + 1;

    function automatic logic wave(input int p, input int t);
        if (p < 2) return 1'b0;
        return (t % p) < (p / 2);
    endfunction

    always_comb begin
        ro_a   = wave(per_a[pair_select], tick);
        ro_b   = wave(per_b[pair_select], tick);
        ro_a_s = wave(per_a_s[pair_select_s], tick);
        ro_b_s = wave(per_b_s[pair_select_s], tick);
    end

    ro_pair_sequencer #(
        .NUM_PAIRS(NP), .PSEL_W(PW), .CNT_W(16),
        .SETTLE_CYCLES(S), .GATE_CYCLES(G)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .ro_a(ro_a), .ro_b(ro_b),
        .enable(enable), .pair_select(pair_select),
        .busy(busy), .done(done), .response(response)
`ifdef RO_COUNT_OUT_EN
        , .cnt_a(cnt_a), .cnt_b(cnt_b), .cnt_valid(cnt_valid)
`endif
    );

    ro_pair_sequencer #(
        .NUM_PAIRS(NP), .PSEL_W(PW), .CNT_W(3),
        .SETTLE_CYCLES(S), .GATE_CYCLES(G)
    ) dut_sat (
        .clk(clk), .reset_n(reset_n), .start(start_s),
        .ro_a(ro_a_s), .ro_b(ro_b_s),
        .enable(enable_s), .pair_select(pair_select_s),
        .busy(busy_s), .done(done_s), .response(response_s)
`ifdef RO_COUNT_OUT_EN
        , .cnt_a(cnt_a_s), .cnt_b(cnt_b_s), .cnt_valid(cnt_valid_s)
`endif
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n === 1'b1 && done === 1'b1) begin
            if (sb_q.size() == 0) begin
                checkOutput("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                checkOutput("done_response", 32'(response), 32'(e.resp));
                checkOutput("done_cycle", cyc, e.done_cyc);
                checkOutput("done_busy_low", 32'(busy), 32'd0);
            end
        end
        if (reset_n === 1'b1 && done_s === 1'b1) begin
            if (sb_s.size() == 0) begin
                checkOutput("sat_unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb_s.pop_front();
                checkOutput("sat_done_response", 32'(response_s), 32'(e.resp));
                checkOutput("sat_done_cycle", cyc, e.done_cyc);
            end
        end
`ifdef RO_COUNT_OUT_EN
        if (cnt_chk && cnt_valid === 1'b1) begin
            cnt_pulses++;
            checkOutput("cnt_a_in_range", 32'(cnt_a == 16'd15 || cnt_a == 16'd16), 32'd1);
        end
`endif
    end

    task automatic waitCyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic setPair(input int i, input int pa, input int pb);
        per_a[i] = pa;
        per_b[i] = pb;
    endtask

    // Issue a one-cycle start on the main DUT from a negedge; k is the
    // sampling edge. done is visible after edge k+RUN, i.e. during the cycle
    // that closes at edge k+RUN+1.
    task automatic applyStimulus(input logic [NP-1:0] exp_resp, output int k);
        exp_t e;
        @(negedge clk);
        k = cyc + 1;
        e.resp = exp_resp;
        e.done_cyc = k + RUN;
        sb_q.push_back(e);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDrain();
        int n = 0;
        while ((sb_q.size() != 0 || sb_s.size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0 || sb_s.size() != 0)
            checkOutput("drain_timeout", 32'd1, 32'd0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int   k, k2;
        exp_t e;

        // Reset values
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        checkOutput("rst_enable", 32'(enable), 32'd0);
        checkOutput("rst_pair_select", 32'(pair_select), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_response", 32'(response), 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("post_rst_busy", 32'(busy), 32'd0);
        checkOutput("post_rst_enable", 32'(enable), 32'd0);

        // Full run, A faster on every pair, with window boundary checks
        $display("[TB] full run, A faster");
        for (int i = 0; i < NP; i++) setPair(i, 4, 8);
`ifdef RO_COUNT_OUT_EN
        cnt_chk = 1'b1;
`endif
        applyStimulus(4'b1111, k);
        for (int i = 0; i < NP; i++) begin
            waitCyc(k + PAIR * i + 10);
            checkOutput("gate_pair_select", 32'(pair_select), i);
            checkOutput("gate_busy", 32'(busy), 32'd1);
            waitCyc(k + PAIR * i + S + G - 1);
            checkOutput("enable_last_gate", 32'(enable), 32'd1);
            waitCyc(k + PAIR * i + S + G);
            checkOutput("enable_low_compare", 32'(enable), 32'd0);
            waitCyc(k + PAIR * i + S + G + 1);
            checkOutput("partial_response", 32'(response), (32'd1 << (i + 1)) - 32'd1);
        end
        waitDrain();
        checkOutput("idle_pair_select", 32'(pair_select), 32'd0);
`ifdef RO_COUNT_OUT_EN
        cnt_chk = 1'b0;
        checkOutput("cnt_valid_pulses", cnt_pulses, 32'd4);
`endif

        // Mixed pairs, plus a start pulse mid-run that must be ignored
        $display("[TB] mixed pairs");
        setPair(0, 4, 8); setPair(1, 8, 4); setPair(2, 4, 8); setPair(3, 8, 4);
        applyStimulus(4'b0101, k);
        checkOutput("response_cleared", 32'(response), 32'd0);
        waitCyc(k + 100);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDrain();

        // start held high: back-to-back runs, response clears on re-accept
        $display("[TB] held start");
        for (int i = 0; i < NP; i++) setPair(i, 4, 8);
        @(negedge clk);
        k = cyc + 1;
        e.resp = 4'b1111; e.done_cyc = k + RUN;       sb_q.push_back(e);
        k2 = k + RUN + 2;
        e.resp = 4'b1111; e.done_cyc = k2 + RUN;      sb_q.push_back(e);
        start = 1'b1;
        waitCyc(k);
        checkOutput("held_first_clear", 32'(response), 32'd0);
        waitCyc(k2 - 1);
        checkOutput("held_idle_busy", 32'(busy), 32'd0);
        checkOutput("held_idle_response", 32'(response), 32'hF);
        waitCyc(k2);
        checkOutput("held_second_busy", 32'(busy), 32'd1);
        checkOutput("held_second_clear", 32'(response), 32'd0);
        start = 1'b0;
        waitDrain();

        // Tie: identical waveforms on both oscillators
        $display("[TB] tie");
        for (int i = 0; i < NP; i++) setPair(i, 6, 6);
        applyStimulus(4'b0000, k);
        waitDrain();

        // Saturation on the 3-bit instance: tie at 7 -> 0, 7 vs 5/6 -> 1
        $display("[TB] saturation");
        @(negedge clk);
        e.resp = 4'b0010;
        e.done_cyc = cyc + 1 + RUN;
        sb_s.push_back(e);
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        waitDrain();

        // Abort during pair 2 GATE
        $display("[TB] abort");
        for (int i = 0; i < NP; i++) setPair(i, 4, 8);
        applyStimulus(4'b1111, k);
        waitCyc(k + 2 * PAIR + 20);
        checkOutput("abort_pre_response", 32'(response), 32'd3);
        checkOutput("abort_pre_pair", 32'(pair_select), 32'd2);
        reset_n = 1'b0;
        sb_q.delete();
        #1;
        checkOutput("abort_enable", 32'(enable), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_response", 32'(response), 32'd0);
        checkOutput("abort_pair_select", 32'(pair_select), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (300) @(negedge clk);
        checkOutput("abort_stays_idle", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/ro_pair_sequencer.md
# ro_pair_sequencer

Sequences a bank of ring-oscillator pairs through a measurement run. On `start` it selects each pair in turn, enables the oscillators, and lets them settle. It then counts rising edges of both oscillators of the pair over a fixed gate window, compares the two counts and records one response bit per pair. It sits between the top-level control and the oscillator bank/mux: it drives `enable` and `pair_select` into the bank and receives the selected pair's two raw oscillator outputs back.

## Interface

Parameters:
- `NUM_PAIRS`, 4: number of oscillator pairs, ≥2.
- `PSEL_W`, 2: `pair_select` width, ≥ clog2(`NUM_PAIRS`).
- `CNT_W`, 16: edge-counter width.
- `SETTLE_CYCLES`, 8: cycles with `enable` high before counting starts, ≥1.
- `GATE_CYCLES`, 1024: counting window in `clk` cycles, ≥1.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: run request, sampled in IDLE only.
- `ro_a`, in, 1: raw output of oscillator A of the selected pair. Asynchronous to `clk`.
- `ro_b`, in, 1: raw output of oscillator B of the selected pair. Asynchronous to `clk`.
- `enable`, out, 1: oscillator enable to the bank.
- `pair_select`, out, `PSEL_W`: index of the pair under measurement.
- `busy`, out, 1: high from start acceptance until `done`.
- `done`, out, 1: one-cycle pulse when the run completes.
- `response`, out, `NUM_PAIRS`: bit i = 1 when pair i count A > count B.

## Operation

- Input conditioning: `ro_a` and `ro_b` each pass through a 2-flop synchronizer and then a rising-edge detector. These run continuously.
- States: IDLE, SETTLE, GATE, COMPARE, NEXT, DONE.
- IDLE: `start`=1 moves to SETTLE with `pair_select`=0, `enable`=1 and `busy`=1. `response` clears to 0 in the same cycle.
- SETTLE: both counters held at 0. The state lasts `SETTLE_CYCLES` cycles, then moves to GATE.
- GATE: each detected edge increments its counter. Counters saturate at 2^`CNT_W`-1 and never wrap. The state lasts `GATE_CYCLES` cycles, then moves to COMPARE.
- COMPARE: `enable`=0. `response[pair_select]` = (cnt_a > cnt_b). A tie gives 0. The state lasts one cycle.
- NEXT: if `pair_select` = `NUM_PAIRS`-1, go to DONE. Otherwise increment `pair_select`, set `enable`=1 and go to SETTLE.
- DONE: `done`=1 and `busy`=0 for one cycle, then go to IDLE. `pair_select` returns to 0.
- `start` is ignored while `busy`=1.
- `response` holds its value after DONE until the next accepted `start`.
- Edge counts are accurate only when the oscillator frequency at this input is < f_clk/2. Prescaling is done in the bank.

## Timing

- Reset values: `enable`=0, `pair_select`=0, `busy`=0, `done`=0, `response`=0, counters=0, state IDLE.
- `reset_n` low in the middle of a run aborts it immediately. All outputs return to their reset values and no `done` is issued.
- Per-pair duration: `SETTLE_CYCLES`+`GATE_CYCLES`+2 cycles.
- `enable` is high for exactly `SETTLE_CYCLES`+`GATE_CYCLES` cycles per pair.
- `start` sampled at edge k gives `done` high in cycle k + `NUM_PAIRS`·(`SETTLE_CYCLES`+`GATE_CYCLES`+2) + 1.
- `response[i]` is valid from the cycle after pair i's COMPARE.
- Synchronizer latency is 2 cycles. Edges still in the synchronizer when GATE ends are dropped, so counts carry ±1 uncertainty.
- `start` held continuously high triggers back-to-back runs. Each new run begins the cycle after the DONE pulse.

## Configuration

- `RO_COUNT_OUT_EN` defined: the block adds three ports:
  - `cnt_a` (out, `CNT_W`) and `cnt_b` (out, `CNT_W`): final counts of the last compared pair, updated in COMPARE and held until the next COMPARE.
  - `cnt_valid` (out, 1): one-cycle pulse in COMPARE.
  - Reset value 0 on all three.
- Not defined: these ports and their registers are absent. All other behaviour is identical.

## Test plan

All scenarios use `NUM_PAIRS`=4, `SETTLE_CYCLES`=4, `GATE_CYCLES`=64.
- Reset values and abort: drive `reset_n` low, then high. All outputs are 0. Start a run, then pull `reset_n` low during pair 2 GATE. `enable`, `busy` and `response` go to 0 and no `done` follows.
- Full run, A faster on every pair: `ro_a` period 4 clk, `ro_b` period 8 clk. `start` at edge k gives `done` at k+281, `response`=4'b1111, `pair_select` stepping 0→3.
- Mixed pairs: A faster on pairs 0 and 2, B faster on pairs 1 and 3. `response`=4'b0101.
- Tie and saturation: identical `ro_a` and `ro_b` give `response` bit 0. With `CNT_W`=3 and period 4, both counts stop at 7 and the bit is 0.
- Start handling: pulse `start` mid-run; no effect on timing or results. Hold `start` high; a second run begins the cycle after `done` and `response` clears.
- Macro on: `RO_COUNT_OUT_EN` defined, `ro_a` period 4. `cnt_valid` pulses 4 times and `cnt_a` is 15 or 16 each time.
